// File: rtl/vmem_xbar_pipe_if.sv
// Request/response bundle between the vector memory read port and the lane crossbar.
// The master modport is the producer/consumer side; the slave modport is the crossbar.
interface vmem_xbar_pipe_if #(
    parameter int unsigned INWIDTH     = 128,
    parameter int unsigned LOG2INWIDTH = 7,
    parameter int unsigned OUTWIDTH    = 32,
    parameter int unsigned NUMLANES    = 8
);
    localparam int unsigned SELWIDTH = LOG2INWIDTH - 3;

    logic                             in_valid;
    logic                             in_ready;
    logic [INWIDTH-1:0]               in_data;
    logic [NUMLANES*SELWIDTH-1:0]     in_sel;
    logic [1:0]                       in_size;
    logic                             in_signed;
    logic [NUMLANES-1:0]              in_mask;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUMLANES*OUTWIDTH-1:0]     out_data;
    logic [NUMLANES-1:0]              out_mask;

    modport master (
        output in_valid, in_data, in_sel, in_size, in_signed, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_mask
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_size, in_signed, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_mask
    );
endinterface

// File: rtl/vmem_xbar_pipe.sv
// Two-stage memory-to-lane crossbar: S1 aligns and extracts raw bytes per lane,
// S2 sign/zero-extends and applies the lane mask. Full valid/ready backpressure.
module vmem_xbar_pipe #(
    parameter int unsigned INWIDTH      = 128,
    parameter int unsigned LOG2INWIDTH  = 7,
    parameter int unsigned OUTWIDTH     = 32,
    parameter int unsigned LOG2OUTWIDTH = 5,
    parameter int unsigned NUMLANES     = 8
) (
    input  logic               clk,
    input  logic               reset,
    vmem_xbar_pipe_if.slave    bus
);
    localparam int unsigned SELWIDTH = LOG2INWIDTH - 3;
    localparam int unsigned NBYTES   = INWIDTH / 8;
    localparam int unsigned OBYTES   = OUTWIDTH / 8;
    localparam int unsigned LANEBITS = NUMLANES * OUTWIDTH;

    localparam logic [SELWIDTH-1:0] HALF_MASK = ~SELWIDTH'(1);
    localparam logic [SELWIDTH-1:0] WORD_MASK = ~SELWIDTH'((1 << (LOG2OUTWIDTH - 3)) - 1);

    // Stage 1 registers
    logic                    s1_valid;
    logic [LANEBITS-1:0]     s1_raw;
    logic [1:0]              s1_size;
    logic                    s1_signed;
    logic [NUMLANES-1:0]     s1_mask;

    // Stage 2 (output) registers
    logic                    out_valid_q;
    logic [LANEBITS-1:0]     out_data_q;
    logic [NUMLANES-1:0]     out_mask_q;

    logic                    s2_adv_c;
    logic                    s1_adv_c;
    logic                    accept_c;
    logic [7:0]              in_bytes_c [NBYTES];
    logic [OBYTES-1:0]       byte_en_c;
    logic [SELWIDTH-1:0]     sel_c [NUMLANES];
    logic [SELWIDTH-1:0]     eff_c [NUMLANES];
    logic [LANEBITS-1:0]     raw_c;
    logic [LANEBITS-1:0]     ext_c;

    // Pipeline advance conditions
    always_comb begin
        s2_adv_c = !out_valid_q || bus.out_ready;
        s1_adv_c = !s1_valid || s2_adv_c;
        accept_c = bus.in_valid && s1_adv_c;
    end

    always_comb begin
        for (int k = 0; k < int'(NBYTES); k++) begin
            in_bytes_c[k] = bus.in_data[8*k +: 8];
        end
    end

    // Bytes of each lane element that come from memory; the rest stay zero
    always_comb begin
        unique case (bus.in_size)
            2'b00:   byte_en_c = OBYTES'(1);
            2'b01:   byte_en_c = OBYTES'(3);
            default: byte_en_c = '1;
        endcase
    end

    // Forced alignment keeps every extracted byte inside the memory bus
    always_comb begin
        raw_c = '0;
        for (int i = 0; i < int'(NUMLANES); i++) begin
            sel_c[i] = bus.in_sel[i*SELWIDTH +: SELWIDTH];
            unique case (bus.in_size)
                2'b00:   eff_c[i] = sel_c[i];
                2'b01:   eff_c[i] = sel_c[i] & HALF_MASK;
                default: eff_c[i] = sel_c[i] & WORD_MASK;
            endcase
            for (int j = 0; j < int'(OBYTES); j++) begin
                if (byte_en_c[j]) begin
                    raw_c[i*OUTWIDTH + 8*j +: 8] = in_bytes_c[eff_c[i] + SELWIDTH'(j)];
                end
            end
        end
    end

    // Extension and lane masking for stage 2
    always_comb begin
        ext_c = '0;
        for (int i = 0; i < int'(NUMLANES); i++) begin
            if (s1_mask[i]) begin
                unique case (s1_size)
                    2'b00: ext_c[i*OUTWIDTH +: OUTWIDTH] =
                        {{(OUTWIDTH-8){s1_signed & s1_raw[i*OUTWIDTH + 7]}},
                         s1_raw[i*OUTWIDTH +: 8]};
                    2'b01: ext_c[i*OUTWIDTH +: OUTWIDTH] =
                        {{(OUTWIDTH-16){s1_signed & s1_raw[i*OUTWIDTH + 15]}},
                         s1_raw[i*OUTWIDTH +: 16]};
                    default: ext_c[i*OUTWIDTH +: OUTWIDTH] = s1_raw[i*OUTWIDTH +: OUTWIDTH];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_raw      <= '0;
            s1_size     <= 2'b00;
            s1_signed   <= 1'b0;
            s1_mask     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mask_q  <= '0;
        end else begin
            if (s1_adv_c) begin
                s1_valid <= bus.in_valid;
                if (accept_c) begin
                    s1_raw    <= raw_c;
                    s1_size   <= bus.in_size;
                    s1_signed <= bus.in_signed;
                    s1_mask   <= bus.in_mask;
                end
            end
            // Output payload only changes on a real transfer into S2
            if (s2_adv_c) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= ext_c;
                    out_mask_q <= s1_mask;
                end
            end
        end
    end

    assign bus.in_ready  = s1_adv_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_mask  = out_mask_q;
endmodule

// File: tb/tb_vmem_xbar_pipe.sv
// Directed and randomised bench for vmem_xbar_pipe with a queue scoreboard
// filled at request acceptance and drained at each output transfer.
module tb_vmem_xbar_pipe;
    localparam int unsigned INW  = 128;
    localparam int unsigned OUTW = 32;
    localparam int unsigned NL   = 8;
    localparam int unsigned SELW = 4;
    localparam int unsigned DW   = NL * OUTW;

    localparam logic [INW-1:0] RAMP = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [INW-1:0] SGN  = 128'h0F0E0D0C0B0A0908FA85050483020100;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NL-1:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic ready_dir;
    logic bp_mode;
    logic rnd_ready;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    vmem_xbar_pipe_if #(.INWIDTH(INW), .LOG2INWIDTH(7), .OUTWIDTH(OUTW), .NUMLANES(NL)) bus ();

    vmem_xbar_pipe #(
        .INWIDTH(INW), .LOG2INWIDTH(7), .OUTWIDTH(OUTW), .LOG2OUTWIDTH(5), .NUMLANES(NL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    assign bus.out_ready = bp_mode ? rnd_ready : ready_dir;
    always @(posedge clk) rnd_ready <= 1'($urandom_range(0, 1));

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [OUTW-1:0] model_lane(input logic [INW-1:0] d, input logic [SELW-1:0] sel,
                                                   input logic [1:0] size, input logic sg);
        int n;
        int off;
        logic [INW-1:0]  sh;
        logic [OUTW-1:0] v;
        logic [OUTW-1:0] keep;
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        off  = (int'(sel) / n) * n;
        sh   = d >> (8 * off);
        v    = sh[OUTW-1:0];
        if (n < 4) begin
            keep = (32'h1 << (8 * n)) - 32'h1;
            v    = v & keep;
            if (sg && v[8*n-1]) v = v | ~keep;
        end
        return v;
    endfunction

    function automatic logic [DW-1:0] model(input logic [INW-1:0] d, input logic [NL*SELW-1:0] sel,
                                            input logic [1:0] size, input logic sg, input logic [NL-1:0] m);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NL); i++) begin
            if (m[i]) r[i*OUTW +: OUTW] = model_lane(d, sel[i*SELW +: SELW], size, sg);
        end
        return r;
    endfunction

    function automatic logic [INW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [INW-1:0] d, input logic [NL*SELW-1:0] sel, input logic [1:0] sz,
                        input logic sg, input logic [NL-1:0] m, input logic [DW-1:0] exp);
        bit acc;
        acc = 1'b0;
        bus.in_data   = d;
        bus.in_sel    = sel;
        bus.in_size   = sz;
        bus.in_signed = sg;
        bus.in_mask   = m;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                sb.push_back('{data: exp, mask: m});
            end
        end
        check1("accept_timeout", acc, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [INW-1:0] d, input logic [NL*SELW-1:0] sel, input logic [1:0] sz,
                              input logic sg, input logic [NL-1:0] m);
        send(d, sel, sz, sg, m, model(d, sel, sz, sg, m));
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 1000 && sb.size() != 0; c++) @(negedge clk);
        check("drain_left", DW'(sb.size()), DW'(0));
    endtask

    // Output side of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            pops++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed %h expected no transfer", bus.out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_data", bus.out_data, e.data);
                check("out_mask", DW'(bus.out_mask), DW'(e.mask));
            end
        end
    end

    initial begin
        logic [INW-1:0]     ra;
        logic [INW-1:0]     rb;
        logic [NL*SELW-1:0] rs;
        logic [DW-1:0]      exp_a;
        int                 p0;

        reset         = 1'b1;
        ready_dir     = 1'b1;
        bp_mode       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.in_size   = 2'b00;
        bus.in_signed = 1'b0;
        bus.in_mask   = '0;

        repeat (3) @(negedge clk);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, DW'(0));
        check("rst_out_mask", DW'(bus.out_mask), DW'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check1("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;

        // Byte routing, plus two-cycle latency
        send(RAMP, 32'hFDB97531, 2'b00, 1'b0, 8'hFF,
             256'h0000000F_0000000D_0000000B_00000009_00000007_00000005_00000003_00000001);
        @(negedge clk);
        check1("latency_s1", bus.out_valid, 1'b0);
        @(negedge clk);
        check1("latency_s2", bus.out_valid, 1'b1);
        @(posedge clk); #1;

        // Sign extension, word alignment, broadcast, mask: back to back
        send(SGN, 32'h33333333, 2'b00, 1'b1, 8'hFF, {8{32'hFFFFFF83}});
        send(SGN, 32'h33333333, 2'b00, 1'b0, 8'hFF, {8{32'h00000083}});
        send(SGN, 32'h77777777, 2'b01, 1'b1, 8'hFF, {8{32'hFFFFFA85}});
        send(SGN, 32'h77777777, 2'b01, 1'b0, 8'hFF, {8{32'h0000FA85}});
        send(RAMP, 32'h66666666, 2'b10, 1'b0, 8'hFF, {8{32'h07060504}});
        send(RAMP, 32'hFFFFFFFF, 2'b10, 1'b0, 8'hFF, {8{32'h0F0E0D0C}});
        send(RAMP, 32'h99999999, 2'b11, 1'b1, 8'hFF, {8{32'h0B0A0908}});
        send(RAMP, 32'hFDB97531, 2'b00, 1'b0, 8'h5A,
             256'h00000000_0000000D_00000000_00000009_00000007_00000000_00000003_00000000);
        send_model(SGN, 32'h0F7E3D61, 2'b01, 1'b1, 8'hFF);
        wait_drain();

        // Backpressure: two held, third ignored while full
        @(posedge clk); #1;
        ready_dir = 1'b0;
        p0 = pops;
        ra = rnd128();
        rs = $urandom();
        exp_a = model(ra, rs, 2'b00, 1'b1, 8'hFF);
        send(ra, rs, 2'b00, 1'b1, 8'hFF, exp_a);
        rb = rnd128();
        send_model(rb, 32'h89ABCDEF, 2'b01, 1'b0, 8'hC3);
        bus.in_data  = ~ra;
        bus.in_mask  = 8'hFF;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check1("bp_in_ready", bus.in_ready, 1'b0);
            check1("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_hold", bus.out_data, exp_a);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        ready_dir    = 1'b1;
        send_model(rnd128(), $urandom(), 2'b10, 1'b0, 8'hFF);
        send_model(rnd128(), $urandom(), 2'b00, 1'b0, 8'h0F);
        wait_drain();
        check("bp_count", DW'(pops - p0), DW'(4));

        // Random traffic with random consumer stalls
        @(posedge clk); #1;
        bp_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send_model(rnd128(), $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       8'($urandom()));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        wait_drain();
        @(posedge clk); #1;
        bp_mode = 1'b0;

        // Asynchronous reset with two requests in flight
        ready_dir = 1'b0;
        send_model(rnd128() | 128'h1, 32'h01234567, 2'b10, 1'b0, 8'hFF);
        send_model(rnd128(), 32'h76543210, 2'b00, 1'b1, 8'hFF);
        @(negedge clk);
        check1("pre_rst_out_valid", bus.out_valid, 1'b1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check1("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_out_data", bus.out_data, DW'(0));
        check("async_rst_out_mask", DW'(bus.out_mask), DW'(0));
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check1("post_rst_in_ready", bus.in_ready, 1'b1);
        ready_dir = 1'b1;
        p0 = pops;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check1("post_rst_no_output", bus.out_valid, 1'b0);
        end
        check("post_rst_pops", DW'(pops - p0), DW'(0));
        @(posedge clk); #1;
        send(RAMP, 32'hFDB97531, 2'b00, 1'b0, 8'hFF,
             256'h0000000F_0000000D_0000000B_00000009_00000007_00000005_00000003_00000001);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
